// File: rtl/uart_tx_sched_pkg.sv
// rtl/uart_tx_sched_pkg.sv - shared types for the UART transmit scheduler
// Scheduler FSM state encoding and byte width used by the queue and the top.
package uart_tx_sched_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      TXQ_IDLE      = 2'd0,
      TXQ_LAUNCH    = 2'd1,
      TXQ_WAIT_BUSY = 2'd2,
      TXQ_WAIT_DONE = 2'd3
   } txq_state_t;

endpackage

// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - launch/busy handshake between scheduler and uart
// The scheduler is the master; the uart answers with busy.
interface uart_tx_sched_if;
   import uart_tx_sched_pkg::*;

   logic              uart_valid;
   logic [DATA_W-1:0] uart_data;
   logic              uart_busy;

   modport master (output uart_valid, output uart_data, input uart_busy);
   modport slave  (input uart_valid, input uart_data, output uart_busy);

endinterface

// File: rtl/uart_tx_sched_txq_fifo_mem.sv
// rtl/uart_tx_sched_txq_fifo_mem.sv - transmit queue storage
// Register array with a synchronous write port and a combinational read port.
module uart_tx_sched_txq_fifo_mem
   import uart_tx_sched_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clock,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - queued transmit scheduler in front of the SOC uart
// Optional drain interrupt built only when UART_TXQ_IRQ_EN is defined.
module uart_tx_sched
   import uart_tx_sched_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
`ifdef UART_TXQ_IRQ_EN
   ,
   parameter int IRQ_THRESH = 2
`endif
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wr_stb,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  flush,
   input  logic                  ovf_clr,
   uart_tx_sched_if.master       uart,
   output logic [DEPTH_LOG2:0]   q_level,
   output logic                  q_empty,
   output logic                  q_full,
   output logic                  ovf,
   output logic                  irq
);

   localparam int                DEPTH      = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_LEVEL = DEPTH[DEPTH_LOG2:0];

   txq_state_t            state;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DATA_W-1:0]     rd_data;
   logic                  pop;
   logic                  push;

   assign q_empty = (q_level == '0);
   assign q_full  = (q_level == FULL_LEVEL);

   // A pop in the same cycle frees a slot, so a push to a full queue still lands.
   assign pop  = (state == TXQ_IDLE) && !q_empty && !uart.uart_busy;
   assign push = wr_stb && !flush && (!q_full || pop);

   uart_tx_sched_txq_fifo_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
      .clock (clock),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= TXQ_IDLE;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         q_level         <= '0;
         ovf             <= 1'b0;
         uart.uart_valid <= 1'b0;
         uart.uart_data  <= '0;
      end else begin
         if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_level <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
               2'b10:   q_level <= q_level + 1'b1;
               2'b01:   q_level <= q_level - 1'b1;
               default: q_level <= q_level;
            endcase
         end

         if (wr_stb && !flush && q_full && !pop) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end

         // The byte is latched at pop and held until the uart releases busy.
         uart.uart_valid <= 1'b0;
         case (state)
            TXQ_IDLE: begin
               if (pop) begin
                  state           <= TXQ_LAUNCH;
                  uart.uart_valid <= 1'b1;
                  uart.uart_data  <= rd_data;
               end
            end
            TXQ_LAUNCH:    state <= TXQ_WAIT_BUSY;
            TXQ_WAIT_BUSY: if (uart.uart_busy)  state <= TXQ_WAIT_DONE;
            TXQ_WAIT_DONE: if (!uart.uart_busy) state <= TXQ_IDLE;
            default:       state <= TXQ_IDLE;
         endcase
      end
   end

`ifdef UART_TXQ_IRQ_EN
   localparam logic [DEPTH_LOG2:0] THRESH_LVL = IRQ_THRESH[DEPTH_LOG2:0];

   logic drained_arm;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         drained_arm <= 1'b0;
         irq         <= 1'b0;
      end else begin
         if (push) begin
            drained_arm <= 1'b0;
         end else if (q_level > THRESH_LVL) begin
            drained_arm <= 1'b1;
         end
         irq <= (q_level <= THRESH_LVL) && drained_arm;
      end
   end
`else
   assign irq = 1'b0;
`endif

endmodule
